// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: op groups, sub-function codes,
// FSM states and flag bit positions.
// Latency/backpressure: n/a (declarations only).
package alu_pkg;

  // Operation groups on the op port
  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_LOGIC = 3'd2;
  localparam logic [2:0] OP_SHIFT = 3'd3;
  localparam logic [2:0] OP_COUNT = 3'd4;
  localparam logic [2:0] OP_MUL   = 3'd5;

  // LOGIC sub-functions
  localparam logic [2:0] FN_AND   = 3'd0;
  localparam logic [2:0] FN_OR    = 3'd1;
  localparam logic [2:0] FN_XOR   = 3'd2;
  localparam logic [2:0] FN_NAND  = 3'd3;
  localparam logic [2:0] FN_NOR   = 3'd4;
  localparam logic [2:0] FN_XNOR  = 3'd5;
  localparam logic [2:0] FN_NOTA  = 3'd6;
  localparam logic [2:0] FN_PASSB = 3'd7;

  // SHIFT sub-functions (5..7 pass a through)
  localparam logic [2:0] SH_SLL = 3'd0;
  localparam logic [2:0] SH_SRL = 3'd1;
  localparam logic [2:0] SH_SRA = 3'd2;
  localparam logic [2:0] SH_ROL = 3'd3;
  localparam logic [2:0] SH_ROR = 3'd4;

  // COUNT sub-functions (4..7 hold)
  localparam logic [2:0] CNT_HOLD = 3'd0;
  localparam logic [2:0] CNT_UP   = 3'd1;
  localparam logic [2:0] CNT_DOWN = 3'd2;
  localparam logic [2:0] CNT_LOAD = 3'd3;

  // Control FSM
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit positions inside flags = {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial-product step per clock.
// Latency: start edge loads operands, then WIDTH step cycles; done marks the last step.
// Backpressure: none; the caller must not restart it while a product is in flight.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH);

  // acc holds {partial high half, remaining multiplier bits}; it shifts right
  // each step so the multiplier LSB always sits at acc[0].
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_n;
  logic [WIDTH:0]     sum;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  // One shift-add step: conditionally add the multiplicand into the high half, then shift.
  always_comb begin
    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
    acc_n = {sum, acc_q[WIDTH-1:1]};
  end

  // The product is taken from the step value so the caller can latch it on the final edge.
  assign done = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign prod = acc_n;

  // Operand load on start, then step until the iteration count runs out.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      mcand_q <= a;
      acc_q   <= {{WIDTH{1'b0}}, b};
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_n;
      cnt_q <= cnt_q + CW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: add/sub, logic, barrel shift/rotate, persistent counter, optional multiply (ALU_SEQ_MUL_EN).
// Latency: 1 cycle for single-cycle ops and illegal ops, WIDTH+1 cycles for MUL.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (no bypass).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [2:0]       fn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             err
);

  state_t           state_q;
  state_t           state_n;
  logic             xfer;
  logic             is_mul;
  logic             mul_done;

  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic             err_q;
  logic [WIDTH-1:0] cnt_q;

  logic [WIDTH-1:0] res_c;
  logic [3:0]       flags_c;
  logic             c_c;
  logic             v_c;
  logic             err_c;
  logic [WIDTH-1:0] cnt_nxt;
  logic             cnt_we;

  logic [WIDTH-1:0] add_b;
  logic [WIDTH:0]   sum_c;
  logic [SHW-1:0]   amt;
  logic [SHW-1:0]   rot_amt;
  logic [WIDTH:0]   sll_t;
  logic [WIDTH:0]   srl_t;
  logic signed [WIDTH:0] sra_t;
  logic [WIDTH-1:0] rot_t;
  logic [WIDTH:0]   cnt_up;
  logic [WIDTH:0]   cnt_dn;

  assign xfer = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   result_hi_q;
  logic [3:0]         mul_flags;

  assign is_mul = (op == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (xfer && is_mul),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  // MUL flags look at the full double-width product; carry/overflow mean the high half is used.
  always_comb begin
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_prod[2*WIDTH-1];
    mul_flags[FLAG_Z] = (mul_prod == '0);
    mul_flags[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
    mul_flags[FLAG_V] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
  end

  // High half is only non-zero after a multiply; any other accepted op clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_hi_q <= '0;
    end else if (xfer && !is_mul) begin
      result_hi_q <= '0;
    end else if (mul_done) begin
      result_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
    end
  end

  assign result_hi = result_hi_q;
`else
  assign is_mul    = 1'b0;
  assign mul_done  = 1'b0;
  assign result_hi = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state: accept in IDLE, iterate in MUL, hold in DONE until consumed.
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_n = is_mul ? S_MUL : S_DONE;
      S_MUL:  if (mul_done) state_n = S_DONE;
      S_DONE: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of state.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // Single-cycle datapath: result, carry, overflow and counter update for the presented op.
  always_comb begin
    res_c   = '0;
    c_c     = 1'b0;
    v_c     = 1'b0;
    err_c   = 1'b0;
    cnt_nxt = cnt_q;
    cnt_we  = 1'b0;
    flags_c = '0;

    // SUB is A + ~B + cin, so cin=1 yields a plain difference and C means "no borrow".
    add_b = (op == OP_SUB) ? ~b : b;
    sum_c = {1'b0, a} + {1'b0, add_b} + {{WIDTH{1'b0}}, cin};

    // Shifts carry an extra guard bit so the last bit shifted out falls into it.
    amt     = b[SHW-1:0];
    rot_amt = ~amt + 1'b1;  // rotate left by n == rotate right by (WIDTH-n) mod WIDTH
    sll_t   = {1'b0, a} << amt;
    srl_t   = {a, 1'b0} >> amt;
    sra_t   = $signed({a, 1'b0}) >>> amt;
    rot_t   = WIDTH'({a, a} >> ((fn == SH_ROL) ? rot_amt : amt));

    cnt_up = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
    cnt_dn = {1'b0, cnt_q} - {{WIDTH{1'b0}}, 1'b1};

    case (op)
      OP_ADD, OP_SUB: begin
        res_c = sum_c[WIDTH-1:0];
        c_c   = sum_c[WIDTH];
        v_c   = (a[WIDTH-1] == add_b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_LOGIC: begin
        case (fn)
          FN_AND:  res_c = a & b;
          FN_OR:   res_c = a | b;
          FN_XOR:  res_c = a ^ b;
          FN_NAND: res_c = ~(a & b);
          FN_NOR:  res_c = ~(a | b);
          FN_XNOR: res_c = ~(a ^ b);
          FN_NOTA: res_c = ~a;
          default: res_c = b;
        endcase
      end
      OP_SHIFT: begin
        case (fn)
          SH_SLL: begin res_c = sll_t[WIDTH-1:0]; c_c = sll_t[WIDTH]; end
          SH_SRL: begin res_c = srl_t[WIDTH:1];   c_c = srl_t[0];     end
          SH_SRA: begin res_c = sra_t[WIDTH:1];   c_c = sra_t[0];     end
          SH_ROL, SH_ROR: res_c = rot_t;
          default: res_c = a;
        endcase
      end
      OP_COUNT: begin
        cnt_we = 1'b1;
        case (fn)
          CNT_UP:   begin cnt_nxt = cnt_up[WIDTH-1:0]; c_c = cnt_up[WIDTH]; end
          CNT_DOWN: begin cnt_nxt = cnt_dn[WIDTH-1:0]; c_c = cnt_dn[WIDTH]; end
          CNT_LOAD: cnt_nxt = a;
          default:  cnt_nxt = cnt_q;
        endcase
        res_c = cnt_nxt;
      end
      default: err_c = 1'b1;  // 6/7, and 5 when the multiplier is not built
    endcase

    // Illegal ops report all-zero flags rather than Z=1 on their zero result.
    if (!err_c) begin
      flags_c[FLAG_N] = res_c[WIDTH-1];
      flags_c[FLAG_Z] = (res_c == '0);
      flags_c[FLAG_C] = c_c;
      flags_c[FLAG_V] = v_c;
    end
  end

  // Result registers load only on an accepted op or multiply completion, so they hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else if (xfer && !is_mul) begin
      result_q <= res_c;
      flags_q  <= flags_c;
      err_q    <= err_c;
    end
`ifdef ALU_SEQ_MUL_EN
    else if (mul_done) begin
      result_q <= mul_prod[WIDTH-1:0];
      flags_q  <= mul_flags;
      err_q    <= 1'b0;
    end
`endif
  end

  // Persistent counter; only COUNT ops touch it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (xfer && cnt_we) begin
      cnt_q <= cnt_nxt;
    end
  end

  assign result = result_q;
  assign flags  = flags_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8; covers the multiplier when ALU_SEQ_MUL_EN is defined.
// Inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Flags are {N,Z,C,V}.
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [2:0]   fn = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [3:0]   flags;
  logic         err;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .fn(fn), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .flags(flags), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for one cycle from IDLE; on return the edge that accepted it has passed.
  task automatic issue(input logic [2:0] o, input logic [2:0] f,
                       input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    op = o; fn = f; a = x; b = y; cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, result, result_hi, flags, err} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0})
      $display("FAIL reset rdy=%b vld=%b res=%h hi=%h flg=%b err=%b want rdy=1 rest 0",
               in_ready, out_valid, result, result_hi, flags, err);
    else passes++;
  endtask

  task automatic test_add();
    issue(3'd0, 3'd0, 8'hFF, 8'h01, 1'b0);
    checks++;
    if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, 8'h00, 4'b0110})
      $display("FAIL add_ff_01 vld=%b rdy=%b res=%h flg=%b want vld=1 rdy=0 res=00 flg=0110",
               out_valid, in_ready, result, flags);
    else passes++;
    consume();
    checks++;
    if ({out_valid, in_ready} !== 2'b01)
      $display("FAIL add_consume vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    else passes++;
  endtask

  task automatic test_sub_hold();
    issue(3'd1, 3'd0, 8'h80, 8'h01, 1'b1);
    // A second request is offered while the result waits; it must be ignored.
    op = 3'd0; a = 8'h01; b = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, 8'h7F, 4'b0011})
        $display("FAIL sub_hold cyc%0d vld=%b rdy=%b res=%h flg=%b want vld=1 rdy=0 res=7f flg=0011",
                 i, out_valid, in_ready, result, flags);
      else passes++;
      tick();
    end
    in_valid = 1'b0;
    consume();
    checks++;
    if ({out_valid, result} !== {1'b0, 8'h7F})
      $display("FAIL sub_no_accept vld=%b res=%h want vld=0 res=7f", out_valid, result);
    else passes++;
  endtask

  task automatic test_logic();
    issue(3'd2, 3'd0, 8'hF0, 8'h3C, 1'b0);
    checks++;
    if ({result, flags} !== {8'h30, 4'b0000})
      $display("FAIL logic_and res=%h flg=%b want 30 0000", result, flags);
    else passes++;
    consume();
    issue(3'd2, 3'd4, 8'hF0, 8'h0F, 1'b1);
    checks++;
    if ({result, flags} !== {8'h00, 4'b0100})
      $display("FAIL logic_nor res=%h flg=%b want 00 0100", result, flags);
    else passes++;
    consume();
    issue(3'd2, 3'd6, 8'h0F, 8'h55, 1'b0);
    checks++;
    if ({result, flags} !== {8'hF0, 4'b1000})
      $display("FAIL logic_nota res=%h flg=%b want f0 1000", result, flags);
    else passes++;
    consume();
  endtask

  task automatic test_shift();
    issue(3'd3, 3'd2, 8'h81, 8'd3, 1'b0);
    checks++;
    if ({result, flags} !== {8'hF0, 4'b1000})
      $display("FAIL shift_sra3 res=%h flg=%b want f0 1000", result, flags);
    else passes++;
    consume();
    issue(3'd3, 3'd3, 8'h81, 8'd9, 1'b0);
    checks++;
    if ({result, flags} !== {8'h03, 4'b0000})
      $display("FAIL shift_rol9 res=%h flg=%b want 03 0000", result, flags);
    else passes++;
    consume();
    issue(3'd3, 3'd0, 8'h81, 8'd1, 1'b0);
    checks++;
    if ({result, flags} !== {8'h02, 4'b0010})
      $display("FAIL shift_sll1 res=%h flg=%b want 02 0010", result, flags);
    else passes++;
    consume();
    issue(3'd3, 3'd1, 8'h81, 8'd1, 1'b0);
    checks++;
    if ({result, flags} !== {8'h40, 4'b0010})
      $display("FAIL shift_srl1 res=%h flg=%b want 40 0010", result, flags);
    else passes++;
    consume();
    issue(3'd3, 3'd0, 8'h81, 8'd8, 1'b0);  // amount 8 wraps to 0
    checks++;
    if ({result, flags} !== {8'h81, 4'b1000})
      $display("FAIL shift_sll_amt0 res=%h flg=%b want 81 1000", result, flags);
    else passes++;
    consume();
    issue(3'd3, 3'd4, 8'h81, 8'd2, 1'b0);
    checks++;
    if ({result, flags} !== {8'h60, 4'b0000})
      $display("FAIL shift_ror2 res=%h flg=%b want 60 0000", result, flags);
    else passes++;
    consume();
  endtask

  task automatic test_count();
    issue(3'd4, 3'd3, 8'hFE, 8'h00, 1'b0);
    checks++;
    if ({result, flags} !== {8'hFE, 4'b1000})
      $display("FAIL count_load res=%h flg=%b want fe 1000", result, flags);
    else passes++;
    consume();
    issue(3'd4, 3'd1, 8'h00, 8'h00, 1'b0);
    checks++;
    if ({result, flags} !== {8'hFF, 4'b1000})
      $display("FAIL count_up1 res=%h flg=%b want ff 1000", result, flags);
    else passes++;
    consume();
    issue(3'd4, 3'd1, 8'h00, 8'h00, 1'b0);
    checks++;
    if ({result, flags} !== {8'h00, 4'b0110})
      $display("FAIL count_up_wrap res=%h flg=%b want 00 0110", result, flags);
    else passes++;
    consume();
    issue(3'd4, 3'd2, 8'h00, 8'h00, 1'b0);
    checks++;
    if ({result, flags} !== {8'hFF, 4'b1010})
      $display("FAIL count_down_wrap res=%h flg=%b want ff 1010", result, flags);
    else passes++;
    consume();
  endtask

  task automatic test_illegal();
    issue(3'd7, 3'd1, 8'h12, 8'h34, 1'b1);
    checks++;
    if ({out_valid, err, result, result_hi, flags} !== {1'b1, 1'b1, 8'h00, 8'h00, 4'h0})
      $display("FAIL illegal_op7 vld=%b err=%b res=%h hi=%h flg=%b want 1 1 00 00 0000",
               out_valid, err, result, result_hi, flags);
    else passes++;
    consume();
`ifndef ALU_SEQ_MUL_EN
    issue(3'd5, 3'd0, 8'hFF, 8'hFF, 1'b0);
    checks++;
    if ({out_valid, err, result, result_hi, flags} !== {1'b1, 1'b1, 8'h00, 8'h00, 4'h0})
      $display("FAIL illegal_op5 vld=%b err=%b res=%h hi=%h flg=%b want 1 1 00 00 0000",
               out_valid, err, result, result_hi, flags);
    else passes++;
    consume();
`endif
    issue(3'd4, 3'd0, 8'h00, 8'h00, 1'b0);
    checks++;
    if ({err, result, flags} !== {1'b0, 8'hFF, 4'b1000})
      $display("FAIL illegal_counter_kept err=%b res=%h flg=%b want 0 ff 1000", err, result, flags);
    else passes++;
    consume();
  endtask

  task automatic test_back_to_back();
    int seen;
    seen = 0;
    op = 3'd0; fn = 3'd0; a = 8'h01; b = 8'h01; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) seen++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (seen !== 3)
      $display("FAIL b2b_throughput got %0d results in 6 cycles want 3", seen);
    else passes++;
    checks++;
    if ({result, in_ready} !== {8'h02, 1'b1})
      $display("FAIL b2b_result res=%h rdy=%b want 02 1", result, in_ready);
    else passes++;
  endtask

  task automatic test_reset_abort();
    issue(3'd1, 3'd0, 8'h05, 8'h03, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, result, result_hi, flags, err} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0})
      $display("FAIL reset_in_done rdy=%b vld=%b res=%h hi=%h flg=%b err=%b want rdy=1 rest 0",
               in_ready, out_valid, result, result_hi, flags, err);
    else passes++;
    issue(3'd4, 3'd0, 8'h00, 8'h00, 1'b0);
    checks++;
    if ({result, flags} !== {8'h00, 4'b0100})
      $display("FAIL reset_counter_clear res=%h flg=%b want 00 0100", result, flags);
    else passes++;
    consume();
  endtask

`ifdef ALU_SEQ_MUL_EN
  task automatic test_mul();
    int lat;
    int seen;
    op = 3'd5; fn = 3'd0; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a = '0; b = '0;
    lat = 1;
    checks++;
    if (in_ready !== 1'b0)
      $display("FAIL mul_busy_ready rdy=%b want 0", in_ready);
    else passes++;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== 9)
      $display("FAIL mul_latency got %0d cycles want 9", lat);
    else passes++;
    checks++;
    if ({result_hi, result, flags, err} !== {8'hFE, 8'h01, 4'b1011, 1'b0})
      $display("FAIL mul_ff_ff hi=%h res=%h flg=%b err=%b want fe 01 1011 0",
               result_hi, result, flags, err);
    else passes++;
    consume();

    issue(3'd5, 3'd0, 8'h10, 8'h10, 1'b0);
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    checks++;
    if ({out_valid, result_hi, result, flags} !== {1'b1, 8'h01, 8'h00, 4'b0011})
      $display("FAIL mul_10_10 vld=%b hi=%h res=%h flg=%b want 1 01 00 0011",
               out_valid, result_hi, result, flags);
    else passes++;
    consume();

    issue(3'd0, 3'd0, 8'h01, 8'h02, 1'b0);
    checks++;
    if ({result_hi, result} !== {8'h00, 8'h03})
      $display("FAIL mul_hi_cleared hi=%h res=%h want 00 03", result_hi, result);
    else passes++;
    consume();

    // Give the counter a non-zero value so the abort visibly clears it.
    issue(3'd4, 3'd3, 8'h55, 8'h00, 1'b0);
    consume();
    issue(3'd5, 3'd0, 8'h07, 8'h09, 1'b0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, result, result_hi, flags, err} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0})
      $display("FAIL mul_reset_abort rdy=%b vld=%b res=%h hi=%h flg=%b err=%b want rdy=1 rest 0",
               in_ready, out_valid, result, result_hi, flags, err);
    else passes++;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0)
      $display("FAIL mul_reset_no_valid got %0d valid cycles want 0", seen);
    else passes++;
    issue(3'd4, 3'd0, 8'h00, 8'h00, 1'b0);
    checks++;
    if ({result, flags} !== {8'h00, 4'b0100})
      $display("FAIL mul_reset_counter res=%h flg=%b want 00 0100", result, flags);
    else passes++;
    consume();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_hold();
    test_logic();
    test_shift();
    test_count();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
`ifdef ALU_SEQ_MUL_EN
    test_mul();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the 8-bit ALU. It adds the following over that design:
  - generic WIDTH;
  - subtract, barrel shift/rotate, and a persistent up/down/load counter;
  - a multi-cycle shift-add multiplier;
  - status flags;
  - a valid/ready handshake, with results registered and held until consumed.
- Sits between the operand register file and the result bus in the datapath.

Parameters:
- WIDTH, 8, operand/result width; must be ≥4 and a power of 2.
- SHW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operation request.
- in_ready, output, 1, block can accept; high only in IDLE.
- op, input, 3, operation group: 0 ADD, 1 SUB, 2 LOGIC, 3 SHIFT, 4 COUNT, 5 MUL, 6/7 illegal.
- fn, input, 3, sub-function for LOGIC/SHIFT/COUNT.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B; for SHIFT, b[SHW-1:0] is the amount.
- cin, input, 1, carry-in for ADD/SUB.
- out_valid, output, 1, result is held and valid.
- out_ready, input, 1, consumer takes the result.
- result, output, WIDTH, result (low half for MUL).
- result_hi, output, WIDTH, MUL high half; 0 for all other ops.
- flags, output, 4, {N,Z,C,V}.
- err, output, 1, illegal op; valid while out_valid is high.

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous, active-high.
- Reset values (all synchronous):
  - state=IDLE, in_ready=1 (combinational from state).
  - out_valid=0, result=0, result_hi=0, flags=0, err=0.
  - counter=0, multiplier registers=0.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - A transfer occurs when in_valid && in_ready; operands are sampled that edge.
  - op≠MUL: result/flags computed and registered that edge; go to DONE, so out_valid=1 on the next cycle (latency 1).
  - op=MUL: load multiplicand/multiplier, iteration count=0; go to MUL.
- MUL:
  - One shift-add step per cycle for exactly WIDTH cycles. On the last step load {result_hi,result}=a*b (unsigned, 2*WIDTH bits) and go to DONE.
  - Latency is WIDTH+1 cycles from acceptance to out_valid.
  - in_ready=0 and inputs are ignored.
- DONE:
  - Outputs are held stable while out_ready=0.
  - When out_ready=1, go to IDLE, out_valid drops next cycle.
  - No bypass: the next op is accepted in IDLE. Maximum throughput is one single-cycle op per 2 cycles.
- ADD/SUB:
  - ADD: {C,r}=a+b+cin.
  - SUB: {C,r}=a+~b+cin; cin=1 gives plain a-b. C=1 means no borrow.
  - V=signed overflow.
- LOGIC fn: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a, 7 pass b. C=V=0.
- SHIFT fn: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, 5–7 pass a.
  - Amount is b[SHW-1:0], i.e. modulo WIDTH; amount 0 returns a.
  - C = last bit shifted out (0 for amount 0 and rotates). V=0.
- COUNT:
  - Counter register persists across ops. fn: 0 hold, 1 up, 2 down, 3 load a, 4–7 hold.
  - result = counter value after update.
  - C=1 when the update wrapped (all-ones→0 up, 0→all-ones down). V=0.
- MUL flags: C=V=(result_hi≠0); Z over the full 2*WIDTH product; N=result_hi MSB.
- Other ops: Z=(result==0), N=result[WIDTH-1].
- Illegal op (6/7): result=0, result_hi=0, flags=0, err=1. Latency 1. Counter is unchanged.
- Reset mid-MUL or in DONE: abort immediately to reset values; the pending result is lost and the counter clears.
- X-safety: when not transferring, the registered outputs do not depend on a/b/op.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL implemented as above.
- Undefined:
  - No multiplier logic and the MUL state is unreachable.
  - op=5 is treated as illegal (err=1, result 0, latency 1).
  - result_hi is tied to 0.

Decomposition:
- Package alu_pkg holds:
  - op codes OP_ADD..OP_MUL;
  - LOGIC/SHIFT/COUNT fn codes;
  - FSM state encodings S_IDLE/S_MUL/S_DONE;
  - flag bit indices FLAG_N/Z/C/V.
- One sub-module, alu_mul_seq: a WIDTH-parametrised shift-add multiplier with start/done, instantiated only under ALU_SEQ_MUL_EN.
- All other logic is inline in alu_seq.

Test Plan (WIDTH=8):
- Reset then ADD: a=0xFF, b=0x01, cin=0, both ready → after 1 cycle result=0x00, flags N0 Z1 C1 V0; in_ready low in DONE.
- SUB signed overflow: a=0x80, b=0x01, cin=1 → result=0x7F, C=1, V=1, N=0. Hold out_ready=0 for 5 cycles → outputs stable and a second in_valid is not accepted.
- SHIFT: a=0x81, b=3, fn=SRA → 0xF0 with C=0. Then fn=ROL, b=9 → amount 1 → 0x03.
- COUNT: load a=0xFE, then up, up → results 0xFE, 0xFF, 0x00; the last has C=1 and Z=1. Then down → 0xFF with C=1.
- MUL (macro on): a=0xFF, b=0xFF → out_valid exactly 9 cycles after acceptance; result_hi=0xFE, result=0x01, C=V=1. Assert rst on cycle 4 of a second MUL → out_valid never rises; all outputs 0 next cycle.
- Illegal op=7 (and op=5 with the macro off) → err=1, result=0, flags=0, counter unchanged.
